// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths and the per-entry flag record
// used by the FP result queue.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam int unsigned FLAG_OVF    = 4;
    localparam int unsigned FLAG_NAN    = 3;
    localparam int unsigned FLAG_INF    = 2;
    localparam int unsigned FLAG_ZERO   = 1;
    localparam int unsigned FLAG_DENORM = 0;

    typedef struct packed {
        logic ovf;
        logic nan;
        logic inf;
        logic zero;
        logic denorm;
    } fp_flags_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for a single-precision value; overflow is not known
// here and is always returned clear.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] value,
    output fp_flags_t   flags
);

    logic [EXP_W-1:0]  exp_field;
    logic [MANT_W-1:0] mant_field;
    logic              mant_zero;

    assign exp_field  = value[30:23];
    assign mant_field = value[22:0];
    assign mant_zero  = (mant_field == '0);

    always_comb begin
        flags        = '0;
        flags.nan    = (exp_field == EXP_MAX) && !mant_zero;
        flags.inf    = (exp_field == EXP_MAX) &&  mant_zero;
        flags.zero   = (exp_field == '0)      &&  mant_zero;
        flags.denorm = (exp_field == '0)      && !mant_zero;
    end

endmodule

// File: rtl/fp_result_queue.sv
// Result queue between the FP add/multiply unit and its consumer; results are
// classified on entry. Define FP_OVF_COUNT_EN to enable the overflow counter.
module fp_result_queue
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_result,
    input  logic                   in_overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic [4:0]             out_flags,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            ovf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] mem_result_q [DEPTH];
    fp_flags_t   mem_flags_q  [DEPTH];

    logic        push, pop;
    logic [31:0] wr_result;
    fp_flags_t   class_flags;
    fp_flags_t   wr_flags;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Overflowed results are replaced by a signed infinity before storage.
    assign wr_result = in_overflow ? {in_result[31], EXP_MAX, {MANT_W{1'b0}}} : in_result;

    fp_classify u_classify (
        .value (wr_result),
        .flags (class_flags)
    );

    always_comb begin
        wr_flags     = class_flags;
        wr_flags.ovf = in_overflow;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result_q[wr_ptr_q] <= wr_result;
            mem_flags_q[wr_ptr_q]  <= wr_flags;
        end
    end

    always_comb begin
        out_result = '0;
        out_flags  = '0;
        if (out_valid) begin
            out_result = mem_result_q[rd_ptr_q];
            out_flags  = mem_flags_q[rd_ptr_q];
        end
    end

`ifdef FP_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else if (push && in_overflow && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_result_queue.sv
// Directed self-checking bench for fp_result_queue (DEPTH = 4).
module tb_fp_result_queue;

    localparam int unsigned DEPTH = 4;
`ifdef FP_OVF_COUNT_EN
    localparam logic [31:0] OVF_EXP = 32'd1;
`else
    localparam logic [31:0] OVF_EXP = 32'd0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [2:0]  count;
    logic [15:0] ovf_cnt;

    int checks;
    int failures;

    fp_result_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .count       (count),
        .ovf_cnt     (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic rdy);
        in_valid    = v;
        in_result   = r;
        in_overflow = o;
        out_ready   = rdy;
    endtask

    logic [31:0] fill_vals [4];
    logic [31:0] cls_vals  [4];
    logic [4:0]  cls_flags [4];

    initial begin
        checks   = 0;
        failures = 0;
        fill_vals = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        cls_vals  = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000001};
        cls_flags = '{5'b01000, 5'b00100, 5'b00010, 5'b00001};

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_result", out_result, 32'h0);
        check_eq("rst_out_flags", 32'(out_flags), 32'h0);
        check_eq("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // Single write, then it drains; no same-cycle bypass.
        drive(1'b1, 32'h3F800000, 1'b0, 1'b1);
        #1;
        check_eq("one_no_bypass", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("one_valid", 32'(out_valid), 32'd1);
        check_eq("one_result", out_result, 32'h3F800000);
        check_eq("one_flags", 32'(out_flags), 32'h0);
        tick();
        check_eq("one_empty", 32'(out_valid), 32'd0);
        check_eq("one_empty_res", out_result, 32'h0);

        // Overflowed write.
        drive(1'b1, 32'hC0000000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("ovf_result", out_result, 32'hFF800000);
        check_eq("ovf_flags", 32'(out_flags), 32'h14);
        check_eq("ovf_cnt", 32'(ovf_cnt), OVF_EXP);
        tick();
        check_eq("ovf_drained", 32'(count), 32'd0);

        // Pop on empty does nothing.
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check_eq("pop_empty_count", 32'(count), 32'd0);

        // Fill to DEPTH, then an ignored fifth write.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_vals[i], 1'b0, 1'b0);
            tick();
        end
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h41000000, 1'b0, 1'b0);
        tick();
        check_eq("full_ignored", 32'(count), 32'd4);
        check_eq("full_head", out_result, 32'h40000000);

        // Full with write and pop together: only the pop happens.
        drive(1'b1, 32'h41100000, 1'b0, 1'b1);
        tick();
        check_eq("full_pop_count", 32'(count), 32'd3);
        check_eq("full_pop_head", out_result, 32'h40400000);
        drive(1'b1, 32'h41100000, 1'b0, 1'b0);
        tick();
        check_eq("refill_count", 32'(count), 32'd4);

        // Drain; write pointer has wrapped past the end.
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("drain0", out_result, 32'h40400000);
        tick();
        check_eq("drain1", out_result, 32'h40800000);
        tick();
        check_eq("drain2", out_result, 32'h40A00000);
        tick();
        check_eq("drain3", out_result, 32'h41100000);
        tick();
        check_eq("drain_empty", 32'(out_valid), 32'd0);

        // Classification of special values.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, cls_vals[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("cls_res%0d", i), out_result, cls_vals[i]);
            check_eq($sformatf("cls_flags%0d", i), 32'(out_flags), 32'(cls_flags[i]));
            tick();
        end

        // Simultaneous write and pop when not full keeps count.
        drive(1'b1, 32'h11111111, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22222222, 1'b0, 1'b1);
        tick();
        check_eq("wp_count", 32'(count), 32'd1);
        check_eq("wp_head", out_result, 32'h22222222);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, fill_vals[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("pre_rst_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_result", out_result, 32'h0);
        check_eq("arst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        drive(1'b1, 32'h3F000000, 1'b0, 1'b0);
        #1;
        check_eq("post_rst_nobyp", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("post_rst_res", out_result, 32'h3F000000);
        check_eq("post_rst_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
